// File: rtl/round_const_pkg.sv
// round_const_pkg: shared definitions for the AES-128 key-expansion round-constant stage.
//   RCON_TABLE  - Rcon values for key-schedule rounds 1..10
//   key_word_t  - 32-bit key word split into bytes, b0 is the most significant byte
//   rcon_of()   - round -> Rcon lookup, 8'h00 for any round outside 1..10
package round_const_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned NUM_ROUNDS = 10;

  // Entry i holds Rcon for round i+1.
  localparam byte_t RCON_TABLE [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef struct packed {
    byte_t b0;
    byte_t b1;
    byte_t b2;
    byte_t b3;
  } key_word_t;

  function automatic logic round_in_range(input logic [3:0] round);
    return (round >= 4'd1) && (round <= 4'd10);
  endfunction

  function automatic byte_t rcon_of(input logic [3:0] round);
    byte_t     result;
    logic [3:0] idx;
    result = 8'h00;
    idx    = round - 4'd1;
    if (round_in_range(round)) begin
      result = RCON_TABLE[idx];
    end
    return result;
  endfunction

endpackage

// File: rtl/rcon_lut.sv
// rcon_lut: combinational key-schedule round -> Rcon lookup.
//   round    in  4  key-schedule round number
//   rcon     out 8  Rcon[round], 8'h00 when round is outside 1..10
//   in_range out 1  round lies in 1..10
module rcon_lut
  import round_const_pkg::*;
(
  input  logic [3:0] round,
  output logic [7:0] rcon,
  output logic       in_range
);

  always_comb begin
    in_range = round_in_range(round);
    rcon     = rcon_of(round);
  end

endmodule

// File: rtl/round_const.sv
// round_const: AES-128 key-expansion round-constant stage, one-cycle latency.
// XORs Rcon[round] into byte 0 of the rotated/substituted key word; bytes 1..3 pass through.
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid                 qualifies round and S*_in this cycle
//   round                    key-schedule round number (1..10 meaningful)
//   S0_in..S3_in             word bytes, S0_in is the most significant byte
//   D0_out..D3_out           registered result word
//   rcon_out                 registered Rcon value that was applied
//   out_valid                one-cycle pulse per accepted input
//   round_err                only when ROUND_CONST_ERR_EN is defined: captured round outside 1..10
module round_const
  import round_const_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] round,
  input  logic [7:0] S0_in,
  input  logic [7:0] S1_in,
  input  logic [7:0] S2_in,
  input  logic [7:0] S3_in,
  output logic [7:0] D0_out,
  output logic [7:0] D1_out,
  output logic [7:0] D2_out,
  output logic [7:0] D3_out,
  output logic [7:0] rcon_out,
  output logic       out_valid
`ifdef ROUND_CONST_ERR_EN
  ,
  output logic       round_err
`endif
);

  logic [7:0] rcon;
  key_word_t  word_in;
  key_word_t  word_d;
  key_word_t  word_q;
  logic [7:0] rcon_q;
  logic       valid_q;

  assign word_in = '{b0: S0_in, b1: S1_in, b2: S2_in, b3: S3_in};

`ifdef ROUND_CONST_ERR_EN
  logic in_range;
  logic err_q;

  rcon_lut u_rcon_lut (
    .round    (round),
    .rcon     (rcon),
    .in_range (in_range)
  );
`else
  // Range flag only feeds the optional error output.
  logic unused_in_range;

  rcon_lut u_rcon_lut (
    .round    (round),
    .rcon     (rcon),
    .in_range (unused_in_range)
  );
`endif

  // Rcon is 00 for out-of-range rounds, so the word passes through untouched there.
  always_comb begin
    word_d    = word_in;
    word_d.b0 = word_in.b0 ^ rcon;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      rcon_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        word_q <= word_d;
        rcon_q <= rcon;
      end
    end
  end

`ifdef ROUND_CONST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_valid) begin
      err_q <= ~in_range;
    end
  end

  assign round_err = err_q;
`endif

  assign D0_out    = word_q.b0;
  assign D1_out    = word_q.b1;
  assign D2_out    = word_q.b2;
  assign D3_out    = word_q.b3;
  assign rcon_out  = rcon_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_round_const.sv
module tb_round_const;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] round;
  logic [7:0] S0_in, S1_in, S2_in, S3_in;
  logic [7:0] D0_out, D1_out, D2_out, D3_out;
  logic [7:0] rcon_out;
  logic       out_valid;
`ifdef ROUND_CONST_ERR_EN
  logic       round_err;
`endif

  round_const dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .round     (round),
    .S0_in     (S0_in),
    .S1_in     (S1_in),
    .S2_in     (S2_in),
    .S3_in     (S3_in),
    .D0_out    (D0_out),
    .D1_out    (D1_out),
    .D2_out    (D2_out),
    .D3_out    (D3_out),
    .rcon_out  (rcon_out),
    .out_valid (out_valid)
`ifdef ROUND_CONST_ERR_EN
    ,
    .round_err (round_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  rcon;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // Monitor: every out_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("D_word", {D0_out, D1_out, D2_out, D3_out}, e.d);
        check("rcon_out", {24'h0, rcon_out}, {24'h0, e.rcon});
`ifdef ROUND_CONST_ERR_EN
        check("round_err", {31'h0, round_err}, {31'h0, e.err});
`endif
      end
    end
  end

  task automatic send(input logic [3:0] r, input logic [31:0] w, input logic [31:0] dexp,
                      input logic [7:0] rc, input logic e);
    exp_t x;
    in_valid = 1'b1;
    round    = r;
    {S0_in, S1_in, S2_in, S3_in} = w;
    x.d = dexp; x.rcon = rc; x.err = e;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
  endtask

  localparam logic [7:0] SWEEP_RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    round    = 4'd0;
    {S0_in, S1_in, S2_in, S3_in} = 32'h0;

    #3;
    check("reset_D_word", {D0_out, D1_out, D2_out, D3_out}, 32'h0);
    check("reset_rcon", {24'h0, rcon_out}, 32'h0);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
`ifdef ROUND_CONST_ERR_EN
    check("reset_round_err", {31'h0, round_err}, 32'h0);
`endif

    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single vector from the key schedule.
    send(4'd1, 32'hb75a9d85, 32'hb65a9d85, 8'h01, 1'b0);
    idle_cycle();

    // Back-to-back sweep of all valid rounds on a zero word.
    for (int i = 0; i < 10; i++) begin
      send(4'(i + 1), 32'h0, {SWEEP_RCON[i], 24'h0}, SWEEP_RCON[i], 1'b0);
    end

    // Out-of-range rounds pass the word unmodified.
    send(4'd0,  32'hffeeddcc, 32'hffeeddcc, 8'h00, 1'b1);
    send(4'd15, 32'hffeeddcc, 32'hffeeddcc, 8'h00, 1'b1);
    send(4'd11, 32'h01020304, 32'h01020304, 8'h00, 1'b1);
    send(4'd10, 32'hc900ff01, 32'hff00ff01, 8'h36, 1'b0);

    // in_valid drops: outputs hold, out_valid deasserts.
    send(4'd9, 32'h12345678, 32'h09345678, 8'h1b, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold_out_valid", {31'h0, out_valid}, 32'h0);
    check("hold_D_word", {D0_out, D1_out, D2_out, D3_out}, 32'h09345678);
    check("hold_rcon", {24'h0, rcon_out}, 32'h0000001b);
    @(negedge clk);
    check("hold2_D_word", {D0_out, D1_out, D2_out, D3_out}, 32'h09345678);

    // Asynchronous reset while out_valid is high.
    @(posedge clk); #2;
    send(4'd3, 32'haabbccdd, 32'haebbccdd, 8'h04, 1'b0);
    check("pre_reset_out_valid", {31'h0, out_valid}, 32'h1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("async_rst_D_word", {D0_out, D1_out, D2_out, D3_out}, 32'h0);
    check("async_rst_rcon", {24'h0, rcon_out}, 32'h0);
    check("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
`ifdef ROUND_CONST_ERR_EN
    check("async_rst_round_err", {31'h0, round_err}, 32'h0);
`endif
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid_a", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("post_rst_out_valid_b", {31'h0, out_valid}, 32'h0);
    check("post_rst_D_word", {D0_out, D1_out, D2_out, D3_out}, 32'h0);

    // Recovery after reset.
    @(posedge clk); #2;
    send(4'd8, 32'h7f000000, 32'hff000000, 8'h80, 1'b0);
    idle_cycle();
    idle_cycle();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
